hwpe_stream_tcdm_addr_reader: RTL

HWPE_STREAM_TCDM_ADDR_READER -- requirements
Module: hwpe_stream_tcdm_addr_reader

---
 rtl/hwpe_stream_tcdm_addr_reader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hwpe_stream_tcdm_addr_reader.sv
// Address-driven TCDM reader: consumes an address stream, issues TCDM reads and
// streams the responses out through a credit-protected response FIFO.
module hwpe_stream_tcdm_addr_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TRANS_CNT  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [TRANS_CNT-1:0]    tot_len_i,
  input  logic                    addr_valid_i,
  output logic                    addr_ready_o,
  input  logic [31:0]             addr_data_i,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [31:0]             tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  input  logic                    tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
  output logic                    data_valid_o,
  input  logic                    data_ready_i,
  output logic [DATA_WIDTH-1:0]   data_data_o,
  output logic [DATA_WIDTH/8-1:0] data_strb_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [TRANS_CNT-1:0]  len_q, len_d;
  logic [TRANS_CNT-1:0]  gnt_cnt_q, gnt_cnt_d;
  logic [TRANS_CNT-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  inflight_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [CW:0]           used;
  logic                  has_credit, granted, fifo_wr, fifo_rd;

  // A grant reserves a FIFO slot until its response lands one cycle later
  assign used       = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
  assign has_credit = used < DEPTH_C;

  assign tcdm_req_o   = (state_q == RUN) && addr_valid_i && has_credit;
  assign granted      = tcdm_req_o && tcdm_gnt_i;
  assign addr_ready_o = granted;
  assign tcdm_add_o   = addr_data_i;
  assign tcdm_wen_o   = 1'b1;
  assign tcdm_be_o    = '1;

  // Only responses to grants still tracked are stored; clear/reset drop them
  assign fifo_wr      = tcdm_r_valid_i && inflight_q && !clear_i;
  assign data_valid_o = (cnt_q != '0);
  assign fifo_rd      = data_valid_o && data_ready_i;
  assign data_data_o  = data_valid_o ? mem_q[rd_ptr_q] : '0;
  assign data_strb_o  = '1;

  assign busy_o = (state_q == RUN) || (state_q == DRAIN);
  assign done_o = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    gnt_cnt_d  = granted ? gnt_cnt_q + TRANS_CNT'(1) : gnt_cnt_q;
    beat_cnt_d = fifo_rd ? beat_cnt_q + TRANS_CNT'(1) : beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d      = tot_len_i;
          gnt_cnt_d  = '0;
          beat_cnt_d = '0;
          state_d    = (tot_len_i == '0) ? DONE : RUN;
        end
      end
      RUN:     if (granted && gnt_cnt_d == len_q) state_d = DRAIN;
      DRAIN:   if (fifo_rd && beat_cnt_d == len_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d    = IDLE;
      gnt_cnt_d  = '0;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      gnt_cnt_q  <= '0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      gnt_cnt_q  <= gnt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      inflight_q <= granted && !clear_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (fifo_wr && !fifo_rd)      cnt_q <= cnt_q + CW'(1);
      else if (fifo_rd && !fifo_wr) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= tcdm_r_data_i;
  end

endmodule
